// File: rtl/riscv_mc_pkg.sv
// Shared encodings for the multicycle RV32I controller: states, opcodes, ALU codes and datapath selects.
package riscv_mc_pkg;

   localparam int unsigned STATE_W  = 4;
   localparam int unsigned OP_W     = 7;
   localparam int unsigned ALUCTL_W = 3;
   localparam int unsigned SEL_W    = 2;

   typedef enum logic [STATE_W-1:0] {
      S_IDLE     = 4'd0,
      S_FETCH    = 4'd1,
      S_DECODE   = 4'd2,
      S_MEMADR   = 4'd3,
      S_MEMREAD  = 4'd4,
      S_MEMWB    = 4'd5,
      S_MEMWRITE = 4'd6,
      S_EXECUTER = 4'd7,
      S_EXECUTEI = 4'd8,
      S_ALUWB    = 4'd9,
      S_BEQ      = 4'd10,
      S_JAL      = 4'd11
   } state_t;

   typedef enum logic [1:0] {
      ALU_OP_ADD   = 2'b00,
      ALU_OP_SUB   = 2'b01,
      ALU_OP_FUNCT = 2'b10
   } alu_op_t;

   localparam logic [OP_W-1:0] OP_LOAD   = 7'b0000011;
   localparam logic [OP_W-1:0] OP_STORE  = 7'b0100011;
   localparam logic [OP_W-1:0] OP_RTYPE  = 7'b0110011;
   localparam logic [OP_W-1:0] OP_ITYPE  = 7'b0010011;
   localparam logic [OP_W-1:0] OP_BRANCH = 7'b1100011;
   localparam logic [OP_W-1:0] OP_JAL    = 7'b1101111;

   localparam logic [ALUCTL_W-1:0] ALU_ADD = 3'b000;
   localparam logic [ALUCTL_W-1:0] ALU_SUB = 3'b001;
   localparam logic [ALUCTL_W-1:0] ALU_AND = 3'b010;
   localparam logic [ALUCTL_W-1:0] ALU_OR  = 3'b011;
   localparam logic [ALUCTL_W-1:0] ALU_SLT = 3'b101;

   localparam logic [SEL_W-1:0] SRC_A_PC     = 2'b00;
   localparam logic [SEL_W-1:0] SRC_A_OLD_PC = 2'b01;
   localparam logic [SEL_W-1:0] SRC_A_RS1    = 2'b10;

   localparam logic [SEL_W-1:0] SRC_B_RS2  = 2'b00;
   localparam logic [SEL_W-1:0] SRC_B_IMM  = 2'b01;
   localparam logic [SEL_W-1:0] SRC_B_FOUR = 2'b10;

   localparam logic [SEL_W-1:0] RES_ALU_OUT    = 2'b00;
   localparam logic [SEL_W-1:0] RES_DATA       = 2'b01;
   localparam logic [SEL_W-1:0] RES_ALU_RESULT = 2'b10;

   localparam logic [SEL_W-1:0] IMM_I = 2'b00;
   localparam logic [SEL_W-1:0] IMM_S = 2'b01;
   localparam logic [SEL_W-1:0] IMM_B = 2'b10;
   localparam logic [SEL_W-1:0] IMM_J = 2'b11;

endpackage

// File: rtl/alu_decoder.sv
// Maps the controller's alu_op request plus instruction function bits onto an ALU operation code.
module alu_decoder
   import riscv_mc_pkg::*;
(
   input  alu_op_t              alu_op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 op5,
   output logic [ALUCTL_W-1:0]  alu_control
);

   always_comb begin
      alu_control = ALU_ADD;
      case (alu_op)
         ALU_OP_ADD: alu_control = ALU_ADD;
         ALU_OP_SUB: alu_control = ALU_SUB;
         ALU_OP_FUNCT: begin
            case (funct3)
               // only R-type (op[5]=1) can encode sub; addi with imm[10]=1 is still add
               3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
               3'b010:  alu_control = ALU_SLT;
               3'b110:  alu_control = ALU_OR;
               3'b111:  alu_control = ALU_AND;
               default: alu_control = ALU_ADD;
            endcase
         end
         default: alu_control = ALU_ADD;
      endcase
   end

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM sequencing the shared multicycle RV32I datapath, stalling on the unified memory handshake.
module multicycle_controller
   import riscv_mc_pkg::*;
(
   input  logic                 clk,
   input  logic                 reset,
   input  logic [OP_W-1:0]      op,
   input  logic [2:0]           funct3,
   input  logic                 funct7b5,
   input  logic                 zero,
   input  logic                 mem_ready,
   output logic                 mem_req,
   output logic                 mem_write,
   output logic                 adr_src,
   output logic                 ir_write,
   output logic                 pc_write,
   output logic                 reg_write,
   output logic [SEL_W-1:0]     alu_src_a,
   output logic [SEL_W-1:0]     alu_src_b,
   output logic [SEL_W-1:0]     result_src,
   output logic [SEL_W-1:0]     imm_src,
   output logic [ALUCTL_W-1:0]  alu_control,
   output logic                 illegal,
   output logic [STATE_W-1:0]   state
);

   state_t  state_q;
   state_t  state_d;
   alu_op_t alu_op;

   // state register; reset is asynchronous so every strobe drops at once
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   assign state = state_q;

   // next-state and state-decoded outputs
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      adr_src    = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      alu_src_a  = SRC_A_PC;
      alu_src_b  = SRC_B_RS2;
      result_src = RES_ALU_OUT;
      alu_op     = ALU_OP_ADD;
      illegal    = 1'b0;
      case (state_q)
         S_IDLE: state_d = S_FETCH;
         S_FETCH: begin
            mem_req    = 1'b1;
            alu_src_a  = SRC_A_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU_RESULT;
            ir_write   = mem_ready;
            pc_write   = mem_ready;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alu_src_a = SRC_A_OLD_PC;
            alu_src_b = SRC_B_IMM;
            case (op)
               OP_LOAD, OP_STORE: state_d = S_MEMADR;
               OP_RTYPE:          state_d = S_EXECUTER;
               OP_ITYPE:          state_d = S_EXECUTEI;
               OP_BRANCH:         state_d = S_BEQ;
               OP_JAL:            state_d = S_JAL;
               default: begin
                  state_d = S_FETCH;
                  illegal = 1'b1;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            state_d   = op[5] ? S_MEMWRITE : S_MEMREAD;
         end
         S_MEMREAD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            result_src = RES_DATA;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_MEMWRITE: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            adr_src   = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_EXECUTER: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_RS2;
            alu_op    = ALU_OP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_a = SRC_A_RS1;
            alu_src_b = SRC_B_IMM;
            alu_op    = ALU_OP_FUNCT;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            result_src = RES_ALU_OUT;
            reg_write  = 1'b1;
            state_d    = S_FETCH;
         end
         S_BEQ: begin
            alu_src_a  = SRC_A_RS1;
            alu_src_b  = SRC_B_RS2;
            alu_op     = ALU_OP_SUB;
            result_src = RES_ALU_OUT;
            pc_write   = ((funct3 == 3'b000) && zero) || ((funct3 == 3'b001) && !zero);
            state_d    = S_FETCH;
         end
         S_JAL: begin
            alu_src_a  = SRC_A_OLD_PC;
            alu_src_b  = SRC_B_FOUR;
            result_src = RES_ALU_OUT;
            pc_write   = 1'b1;
            state_d    = S_ALUWB;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // immediate format follows the opcode regardless of state
   always_comb begin
      case (op)
         OP_STORE:  imm_src = IMM_S;
         OP_BRANCH: imm_src = IMM_B;
         OP_JAL:    imm_src = IMM_J;
         default:   imm_src = IMM_I;
      endcase
   end

   alu_decoder u_alu_decoder (
      .alu_op      (alu_op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .op5         (op[5]),
      .alu_control (alu_control)
   );

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed per-cycle expectations checked by a negedge monitor.
module tb_multicycle_controller;

   typedef struct packed {
      logic [3:0] st;
      logic       mreq;
      logic       mwr;
      logic       adr;
      logic       irw;
      logic       pcw;
      logic       regw;
      logic [1:0] sa;
      logic [1:0] sb;
      logic [1:0] rs;
      logic [1:0] imm;
      logic [2:0] ac;
      logic       ill;
   } exp_t;

   localparam logic [6:0] LW   = 7'b0000011;
   localparam logic [6:0] SW   = 7'b0100011;
   localparam logic [6:0] RT   = 7'b0110011;
   localparam logic [6:0] IT   = 7'b0010011;
   localparam logic [6:0] BR   = 7'b1100011;
   localparam logic [6:0] JL   = 7'b1101111;
   localparam logic [6:0] BAD  = 7'b1111111;

   logic       clk = 1'b0;
   logic       reset;
   logic [6:0] op;
   logic [2:0] funct3;
   logic       funct7b5;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal;
   logic [1:0] alu_src_a, alu_src_b, result_src, imm_src;
   logic [2:0] alu_control;
   logic [3:0] state;

   int tests = 0;
   int fails = 0;
   exp_t  exp_q[$];
   string tag_q[$];

   always #5 clk = ~clk;

   multicycle_controller dut (
      .clk         (clk),
      .reset       (reset),
      .op          (op),
      .funct3      (funct3),
      .funct7b5    (funct7b5),
      .zero        (zero),
      .mem_ready   (mem_ready),
      .mem_req     (mem_req),
      .mem_write   (mem_write),
      .adr_src     (adr_src),
      .ir_write    (ir_write),
      .pc_write    (pc_write),
      .reg_write   (reg_write),
      .alu_src_a   (alu_src_a),
      .alu_src_b   (alu_src_b),
      .result_src  (result_src),
      .imm_src     (imm_src),
      .alu_control (alu_control),
      .illegal     (illegal),
      .state       (state)
   );

   // expected fixed per-state outputs; dynamic fields are passed in hand-computed
   function automatic exp_t ex(input logic [3:0] st, input logic [1:0] imm, input logic irw,
                               input logic pcw, input logic [2:0] ac, input logic ill);
      exp_t e;
      e = '0;
      e.st = st; e.imm = imm; e.irw = irw; e.pcw = pcw; e.ac = ac; e.ill = ill;
      case (st)
         4'd1:  begin e.mreq = 1'b1; e.sb = 2'b10; e.rs = 2'b10; end
         4'd2:  begin e.sa = 2'b01; e.sb = 2'b01; end
         4'd3:  begin e.sa = 2'b10; e.sb = 2'b01; end
         4'd4:  begin e.mreq = 1'b1; e.adr = 1'b1; end
         4'd5:  begin e.rs = 2'b01; e.regw = 1'b1; end
         4'd6:  begin e.mreq = 1'b1; e.mwr = 1'b1; e.adr = 1'b1; end
         4'd7:  begin e.sa = 2'b10; end
         4'd8:  begin e.sa = 2'b10; e.sb = 2'b01; end
         4'd9:  begin e.regw = 1'b1; end
         4'd10: begin e.sa = 2'b10; end
         4'd11: begin e.sa = 2'b01; e.sb = 2'b10; end
         default: ;
      endcase
      return e;
   endfunction

   task automatic push(input string tag, input exp_t e);
      exp_q.push_back(e);
      tag_q.push_back(tag);
   endtask

   // one clock cycle: inputs driven just after the edge, expectation for that cycle queued
   task automatic cyc(input string tag, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                      input logic z, input logic rdy, input exp_t e);
      @(posedge clk);
      #1;
      op = o; funct3 = f3; funct7b5 = f7; zero = z; mem_ready = rdy;
      push(tag, e);
   endtask

   task automatic fetch_decode(input string tag, input logic [6:0] o, input logic [2:0] f3,
                               input logic f7, input logic z, input logic [1:0] imm);
      cyc({tag, "_fetch"},  o, f3, f7, z, 1'b1, ex(4'd1, imm, 1'b1, 1'b1, 3'b000, 1'b0));
      cyc({tag, "_decode"}, o, f3, f7, z, 1'b0, ex(4'd2, imm, 1'b0, 1'b0, 3'b000, 1'b0));
   endtask

   task automatic alu_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                            input logic f7, input logic [2:0] ac);
      fetch_decode(tag, o, f3, f7, 1'b0, 2'b00);
      cyc({tag, "_exec"},  o, f3, f7, 1'b0, 1'b1, ex((o == RT) ? 4'd7 : 4'd8, 2'b00, 1'b0, 1'b0, ac, 1'b0));
      cyc({tag, "_aluwb"}, o, f3, f7, 1'b0, 1'b1, ex(4'd9, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
   endtask

   task automatic branch(input string tag, input logic [2:0] f3, input logic z, input logic pcw);
      fetch_decode(tag, BR, f3, 1'b0, z, 2'b10);
      cyc({tag, "_beq"}, BR, f3, 1'b0, z, 1'b0, ex(4'd10, 2'b10, 1'b0, pcw, 3'b001, 1'b0));
   endtask

   // monitor: compare DUT outputs to the oldest queued expectation, away from the clock edge
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t  e;
         exp_t  g;
         string t;
         e = exp_q.pop_front();
         t = tag_q.pop_front();
         g = {state, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
              alu_src_a, alu_src_b, result_src, imm_src, alu_control, illegal};
         if (e.st == 4'd0) begin
            g.imm = 2'b00;
            e.imm = 2'b00;
         end
         tests++;
         if (g !== e) begin
            fails++;
            $display("FAIL %s: got st=%0d req=%b wr=%b adr=%b irw=%b pcw=%b rw=%b a=%b b=%b rs=%b imm=%b ac=%b ill=%b, required st=%0d req=%b wr=%b adr=%b irw=%b pcw=%b rw=%b a=%b b=%b rs=%b imm=%b ac=%b ill=%b",
                     t, g.st, g.mreq, g.mwr, g.adr, g.irw, g.pcw, g.regw, g.sa, g.sb, g.rs, g.imm, g.ac, g.ill,
                     e.st, e.mreq, e.mwr, e.adr, e.irw, e.pcw, e.regw, e.sa, e.sb, e.rs, e.imm, e.ac, e.ill);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      reset = 1'b0; op = LW; funct3 = 3'b000; funct7b5 = 1'b0; zero = 1'b0; mem_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      push("rel_idle", ex(4'd0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));

      // lw with memory always ready: 1,2,3,4,5
      fetch_decode("lw", LW, 3'b010, 1'b0, 1'b0, 2'b00);
      cyc("lw_memadr",  LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd3, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("lw_memread", LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd4, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("lw_memwb",   LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd5, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));

      // stalled fetch of an R-type sub
      for (int i = 0; i < 3; i++)
         cyc("stall_fetch", RT, 3'b000, 1'b1, 1'b0, 1'b0, ex(4'd1, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      alu_instr("sub", RT, 3'b000, 1'b1, 3'b001);
      alu_instr("add", RT, 3'b000, 1'b0, 3'b000);
      alu_instr("slt", RT, 3'b010, 1'b0, 3'b101);
      alu_instr("or",  RT, 3'b110, 1'b0, 3'b011);
      alu_instr("addi_f7", IT, 3'b000, 1'b1, 3'b000);
      alu_instr("andi", IT, 3'b111, 1'b0, 3'b010);

      branch("beq_z1", 3'b000, 1'b1, 1'b1);
      branch("beq_z0", 3'b000, 1'b0, 1'b0);
      branch("bne_z0", 3'b001, 1'b0, 1'b1);
      branch("bne_z1", 3'b001, 1'b1, 1'b0);

      fetch_decode("jal", JL, 3'b000, 1'b0, 1'b0, 2'b11);
      cyc("jal_jal",   JL, 3'b000, 1'b0, 1'b0, 1'b0, ex(4'd11, 2'b11, 1'b0, 1'b1, 3'b000, 1'b0));
      cyc("jal_aluwb", JL, 3'b000, 1'b0, 1'b0, 1'b0, ex(4'd9, 2'b11, 1'b0, 1'b0, 3'b000, 1'b0));

      // lw with one wait state on the data read
      fetch_decode("lw2", LW, 3'b010, 1'b0, 1'b0, 2'b00);
      cyc("lw2_memadr",   LW, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd3, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("lw2_rd_stall", LW, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd4, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("lw2_memread",  LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd4, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("lw2_memwb",    LW, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd5, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));

      // illegal opcode: single pulse in DECODE, then straight back to FETCH
      cyc("bad_fetch",  BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex(4'd1, 2'b00, 1'b1, 1'b1, 3'b000, 1'b0));
      cyc("bad_decode", BAD, 3'b000, 1'b0, 1'b0, 1'b1, ex(4'd2, 2'b00, 1'b0, 1'b0, 3'b000, 1'b1));

      // sw with ready memory, then sw stalled and reset mid-write
      fetch_decode("sw", SW, 3'b010, 1'b0, 1'b0, 2'b01);
      cyc("sw_memadr",   SW, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd3, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("sw_memwrite", SW, 3'b010, 1'b0, 1'b0, 1'b1, ex(4'd6, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      fetch_decode("sw2", SW, 3'b010, 1'b0, 1'b0, 2'b01);
      cyc("sw2_memadr", SW, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd3, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("sw2_wr_stall", SW, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd6, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      cyc("sw2_wr_stall", SW, 3'b010, 1'b0, 1'b0, 1'b0, ex(4'd6, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      tests++;
      if (state !== 4'd0 || mem_write !== 1'b0 || mem_req !== 1'b0) begin
         fails++;
         $display("FAIL reset_async: got state=%0d mem_write=%b mem_req=%b, required state=0 mem_write=0 mem_req=0",
                  state, mem_write, mem_req);
      end
      push("rst_mid", ex(4'd0, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      @(posedge clk);
      #1;
      mem_ready = 1'b1;
      push("rst_hold", ex(4'd0, 2'b01, 1'b0, 1'b0, 3'b000, 1'b0));
      @(posedge clk);
      #1;
      reset = 1'b1;
      op = IT; funct3 = 3'b110;
      push("rst_rel", ex(4'd0, 2'b00, 1'b0, 1'b0, 3'b000, 1'b0));
      alu_instr("ori", IT, 3'b110, 1'b0, 3'b011);

      repeat (2) @(posedge clk);
      @(negedge clk);
      #1;
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control FSM for the multicycle RV32I core: it sequences one shared datapath (single ALU, one unified memory port, instruction/data registers) through fetch, decode, execute, memory and writeback steps. It replaces the single-cycle combinational controller, drives every datapath mux select and write strobe, and stalls on a ready/request handshake with the unified memory.

## Interface
- No parameters. Encodings are fixed in the shared package.
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  7  instr[6:0], from the instruction register
- funct3  in  3  instr[14:12]
- funct7b5  in  1  instr[30]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current request this cycle
- mem_req  out  1  memory request (FETCH, MEMREAD, MEMWRITE)
- mem_write  out  1  write request (MEMWRITE only)
- adr_src  out  1  memory address select: 0 = pc, 1 = alu_out
- ir_write  out  1  load instruction register and old_pc
- pc_write  out  1  load pc from result
- reg_write  out  1  register file write enable
- alu_src_a  out  2  ALU A select: 00 = pc, 01 = old_pc, 10 = rs1
- alu_src_b  out  2  ALU B select: 00 = rs2, 01 = imm, 10 = const 4
- result_src  out  2  result select: 00 = alu_out, 01 = data reg, 10 = alu_result
- imm_src  out  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J
- alu_control  out  3  ALU op: 000 add, 001 sub, 010 and, 011 or, 101 slt
- illegal  out  1  one-cycle pulse on an unsupported opcode
- state  out  4  current state, for debug

## Operation
- Moore FSM. Outputs decode from the state only, except: pc_write in BEQ (uses zero/funct3); ir_write, pc_write and the state exits in FETCH/MEMREAD/MEMWRITE (use mem_ready); imm_src and alu_control.
- Any output not listed for a state is 0.
- States: IDLE=0, FETCH=1, DECODE=2, MEMADR=3, MEMREAD=4, MEMWB=5, MEMWRITE=6, EXECUTER=7, EXECUTEI=8, ALUWB=9, BEQ=10, JAL=11.
- IDLE
  - All outputs 0.
  - Always goes to FETCH.
- FETCH
  - mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=add, result_src=10.
  - ir_write=pc_write=mem_ready.
  - Goes to DECODE when mem_ready; otherwise stays.
- DECODE
  - alu_src_a=01, alu_src_b=01, add (precomputes the branch/jump target).
  - Next state by op: 0000011 or 0100011 -> MEMADR; 0110011 -> EXECUTER; 0010011 -> EXECUTEI; 1100011 -> BEQ; 1101111 -> JAL.
  - Any other op -> FETCH with illegal=1.
- MEMADR
  - alu_src_a=10, alu_src_b=01, add.
  - op[5]=0 -> MEMREAD; op[5]=1 -> MEMWRITE.
- MEMREAD
  - mem_req=1, adr_src=1.
  - mem_ready -> MEMWB; otherwise stays.
- MEMWB
  - result_src=01, reg_write=1.
  - Goes to FETCH.
- MEMWRITE
  - mem_req=1, mem_write=1, adr_src=1.
  - mem_ready -> FETCH; otherwise stays.
- EXECUTER
  - alu_src_a=10, alu_src_b=00, alu_op=funct.
  - Goes to ALUWB.
- EXECUTEI
  - alu_src_a=10, alu_src_b=01, alu_op=funct.
  - Goes to ALUWB.
- ALUWB
  - result_src=00, reg_write=1.
  - Goes to FETCH.
- BEQ
  - alu_src_a=10, alu_src_b=00, sub, result_src=00.
  - pc_write = (funct3==000 & zero) | (funct3==001 & !zero).
  - Goes to FETCH.
- JAL
  - alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1.
  - Goes to ALUWB.
- alu_control decode
  - alu_op=add -> 000; alu_op=sub -> 001.
  - alu_op=funct, by funct3:
    - 000 -> sub if op[5]&funct7b5, else add
    - 010 -> 101
    - 110 -> 011
    - 111 -> 010
    - other -> 000
- imm_src, combinational from op: 0100011 -> 01; 1100011 -> 10; 1101111 -> 11; else 00.

## Timing
- State register updates on the rising clk edge. reset low forces IDLE immediately, at any point (including mid-MEMWRITE or a stalled fetch); all strobes drop to 0 without waiting for a clock.
- First FETCH occurs on the first edge after reset deasserts.
- Cycles per instruction with zero wait states, counted FETCH through the last state: lw 5; sw, R, I and jal 4; branch 3.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle. Outputs are held stable while stalled.
- mem_ready outside a request state is ignored.
- illegal is high only during the DECODE cycle of the bad instruction.

## Structure
- Package riscv_mc_pkg holds:
  - state enum
  - opcode constants
  - alu_op codes (add, sub, funct)
  - alu_control codes
  - alu_src_a, alu_src_b and result_src select constants
- Sub-module alu_decoder: combinational mapping of alu_op/funct3/funct7b5/op[5] to alu_control; instantiated once.

## Test plan
- Reset release, lw (op 0000011), mem_ready tied 1 -> state sequence 0,1,2,3,4,5,1; reg_write high only in state 5; result_src=01 there.
- FETCH with mem_ready low for 3 cycles -> state holds at 1 with mem_req=1, ir_write=0, pc_write=0; DECODE follows the cycle after mem_ready rises.
- R-type: funct3=000, funct7b5=1 -> EXECUTER alu_control=001; with funct7b5=0 -> 000. I-type: funct3=000, funct7b5=1 -> 000.
- beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> 0. bne (funct3=001), zero=0 -> pc_write=1.
- sw in MEMWRITE with mem_ready low; reset pulsed low mid-cycle -> state=0 and mem_write=0 immediately; FETCH on the first edge after release.
- op=1111111 -> illegal pulses for exactly one cycle in DECODE; next state is FETCH; reg_write is never asserted.
